// File: rtl/sisc_fetch_if.sv
// Instruction-memory read bus for the SISC fetch unit.
// master: fetch unit (drives address/request); slave: instruction memory.
interface sisc_fetch_if #(
  parameter int unsigned AW = 8
) ();
  logic [AW-1:0] im_addr;
  logic          im_req;
  logic          im_ack;
  logic [31:0]   im_data;

  modport master (
    output im_addr,
    output im_req,
    input  im_ack,
    input  im_data
  );

  modport slave (
    input  im_addr,
    input  im_req,
    output im_ack,
    output im_data
  );
endinterface

// File: rtl/sisc_fetch.sv
// SISC instruction-fetch unit: owns PC and IR, runs the req/ack read to
// instruction memory and resolves BRA/BRR/BNE/BNR against the ALU status.
// Optional build macro FETCH_TIMEOUT_EN: aborts a fetch that waits TIMEOUT
// cycles without an ack, loading HLT and setting a sticky error flag.
module sisc_fetch #(
  parameter int unsigned AW      = 8
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req_i,
  input  logic          br_eval_i,
  input  logic [3:0]    stat_i,
  sisc_fetch_if.master  im,
  output logic [31:0]   ir_o,
  output logic [3:0]    opcode_o,
  output logic [3:0]    mm_o,
  output logic [AW-1:0] pc_o,
  output logic          busy_o,
  output logic          fetch_done_o,
  output logic          fetch_err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] OpBra = 4'd4;
  localparam logic [3:0] OpBrr = 4'd5;
  localparam logic [3:0] OpBne = 4'd6;
  localparam logic [3:0] OpBnr = 4'd7;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   ir_q;
  logic          im_req_q;
  logic          busy_q;
  logic          fetch_done_q;

  logic          hit;
  logic [31:0]   rel_off;
  logic [AW-1:0] br_pc_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] cnt_q;
  logic            fetch_err_q;
`endif

  // Branch target: relative forms add to the already-incremented PC and wrap.
  always_comb begin
    hit     = |(stat_i & ir_q[27:24]);
    rel_off = {{16{ir_q[15]}}, ir_q[15:0]};
    br_pc_d = pc_q;
    case (ir_q[31:28])
      OpBra: if (hit)  br_pc_d = ir_q[AW-1:0];
      OpBrr: if (hit)  br_pc_d = pc_q + rel_off[AW-1:0];
      OpBne: if (!hit) br_pc_d = ir_q[AW-1:0];
      OpBnr: if (!hit) br_pc_d = pc_q + rel_off[AW-1:0];
      default: ;
    endcase
  end

  // Fetch FSM with registered handshake/status outputs; PC and IR live here too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      im_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      fetch_done_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q        <= '0;
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          fetch_done_q <= 1'b0;
          // Branch lands first so a same-cycle fetch reads from the new PC.
          if (br_eval_i) pc_q <= br_pc_d;
          if (fetch_req_i) begin
            state_q  <= StWait;
            im_req_q <= 1'b1;
            busy_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        StWait: begin
          if (im.im_ack) begin
            ir_q         <= im.im_data;
            pc_q         <= pc_q + AW'(1);
            im_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            fetch_done_q <= 1'b1;
            state_q      <= StDone;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == CntLast) begin
            // Abort: substitute HLT, keep PC, latch the error.
            ir_q         <= 32'hF000_0000;
            fetch_err_q  <= 1'b1;
            im_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            fetch_done_q <= 1'b1;
            state_q      <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        StDone: begin
          fetch_done_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign im.im_req    = im_req_q;
  assign im.im_addr   = im_req_q ? pc_q : '0;
  assign ir_o         = ir_q;
  assign opcode_o     = ir_q[31:28];
  assign mm_o         = ir_q[27:24];
  assign pc_o         = pc_q;
  assign busy_o       = busy_q;
  assign fetch_done_o = fetch_done_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err_o  = fetch_err_q;
`else
  assign fetch_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: directed and randomized fetch/branch transactions,
// each checked against a transaction-level model of PC/IR.
module tb_sisc_fetch;
  localparam int unsigned AW   = 8;
  localparam int unsigned MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic          br_eval;
  logic [3:0]    stat;
  logic [31:0]   ir;
  logic [3:0]    opcode;
  logic [3:0]    mm;
  logic [AW-1:0] pc;
  logic          busy;
  logic          fetch_done;
  logic          fetch_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int unsigned m_pc;
  logic [31:0] m_ir;
  logic        m_err;

  sisc_fetch_if #(.AW(AW)) bus ();

  sisc_fetch #(.AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req_i  (fetch_req),
    .br_eval_i    (br_eval),
    .stat_i       (stat),
    .im           (bus.master),
    .ir_o         (ir),
    .opcode_o     (opcode),
    .mm_o         (mm),
    .pc_o         (pc),
    .busy_o       (busy),
    .fetch_done_o (fetch_done),
    .fetch_err_o  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Branch semantics from the ISA rules, using plain integer arithmetic.
  function automatic int unsigned br_target(input int unsigned cur_pc, input logic [31:0] instr,
                                            input logic [3:0] st);
    bit hit;
    int off;
    int unsigned abs_t;
    int unsigned rel_t;
    hit   = (st & instr[27:24]) != 4'd0;
    off   = int'($signed(instr[15:0]));
    abs_t = instr & MASK;
    rel_t = int'(unsigned'(int'(cur_pc) + off)) & MASK;
    case (int'(instr[31:28]))
      4:       return hit ? abs_t : cur_pc;
      5:       return hit ? rel_t : cur_pc;
      6:       return hit ? cur_pc : abs_t;
      7:       return hit ? cur_pc : rel_t;
      default: return cur_pc;
    endcase
  endfunction

  task automatic do_branch(input logic [3:0] st);
    br_eval = 1'b1;
    stat    = st;
    m_pc    = br_target(m_pc, m_ir, st);
    step();
    br_eval = 1'b0;
    chk("br_pc", pc, m_pc);
    chk("br_busy", busy, 0);
  endtask

  // One fetch with k wait states; optional stray strobes and same-cycle branch.
  task automatic do_fetch(input int k, input logic [31:0] data, input bit stray,
                          input bit with_br, input logic [3:0] st);
    fetch_req = 1'b1;
    if (with_br) begin
      br_eval = 1'b1;
      stat    = st;
      m_pc    = br_target(m_pc, m_ir, st);
    end
    step();
    fetch_req = 1'b0;
    br_eval   = 1'b0;
    for (int i = 0; i <= k; i++) begin
      chk("wait_req", bus.im_req, 1);
      chk("wait_busy", busy, 1);
      chk("wait_addr", bus.im_addr, m_pc);
      chk("wait_ir", ir, m_ir);
      chk("wait_done", fetch_done, 0);
      if (i == k) begin
        bus.im_ack  = 1'b1;
        bus.im_data = data;
      end else begin
        bus.im_ack  = 1'b0;
        bus.im_data = $urandom;
        fetch_req   = stray;
        br_eval     = stray;
        stat        = 4'($urandom);
      end
      step();
      fetch_req = 1'b0;
      br_eval   = 1'b0;
    end
    m_ir = data;
    m_pc = (m_pc + 1) & MASK;
    // Ack and request during the done cycle must both be ignored.
    bus.im_ack  = 1'($urandom_range(0, 1));
    bus.im_data = $urandom;
    fetch_req   = stray;
    chk("done_pulse", fetch_done, 1);
    chk("done_busy", busy, 0);
    chk("done_req", bus.im_req, 0);
    chk("done_ir", ir, m_ir);
    chk("done_opcode", opcode, m_ir[31:28]);
    chk("done_mm", mm, m_ir[27:24]);
    chk("done_pc", pc, m_pc);
    chk("done_err", fetch_err, m_err);
    step();
    bus.im_ack = 1'b0;
    fetch_req  = 1'b0;
    chk("idle_done", fetch_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_req", bus.im_req, 0);
    chk("idle_addr", bus.im_addr, 0);
    chk("idle_ir", ir, m_ir);
    chk("idle_pc", pc, m_pc);
  endtask

  initial begin
    logic [31:0] rdata;
    logic [3:0]  rop;
    rst         = 1'b1;
    fetch_req   = 1'b0;
    br_eval     = 1'b0;
    stat        = 4'd0;
    bus.im_ack  = 1'b0;
    bus.im_data = 32'd0;
    m_pc        = 0;
    m_ir        = 32'd0;
    m_err       = 1'b0;
    #3;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_req", bus.im_req, 0);
    chk("rst_addr", bus.im_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", fetch_done, 0);
    chk("rst_err", fetch_err, 0);
    step();
    rst = 1'b0;
    step();

    // Basic fetch, ack one cycle after the request appears.
    do_fetch(1, 32'h1234_0001, 1'b0, 1'b0, 4'd0);
    chk("basic_opcode", opcode, 4'd1);
    chk("basic_mm", mm, 4'd2);
    chk("basic_pc", pc, 1);

    // Three wait states with stray fetch_req/br_eval while waiting.
    do_fetch(3, 32'h0000_0000, 1'b1, 1'b0, 4'd0);

    // BRA taken and not taken.
    do_fetch(0, 32'h4100_0020, 1'b0, 1'b0, 4'd0);
    do_branch(4'd1);
    chk("bra_taken", pc, 8'h20);
    do_branch(4'd0);
    chk("bra_not", pc, 8'h20);

    // BNR wraps forward past the top and backward.
    do_fetch(0, 32'h4100_00FD, 1'b0, 1'b0, 4'd0);
    do_branch(4'd1);
    do_fetch(0, 32'h7100_0005, 1'b0, 1'b0, 4'd0);
    chk("bnr_pre", pc, 8'hFE);
    do_branch(4'd0);
    chk("bnr_wrap", pc, 8'h03);
    do_fetch(0, 32'h4100_00FD, 1'b0, 1'b0, 4'd0);
    do_branch(4'd1);
    do_fetch(2, 32'h7100_FFFC, 1'b0, 1'b0, 4'd0);
    do_branch(4'd0);
    chk("bnr_back", pc, 8'hFA);

    // Branch and fetch in the same cycle: fetch addresses the branch target.
    do_fetch(0, 32'h4200_0040, 1'b0, 1'b0, 4'd0);
    do_fetch(1, 32'h5300_0010, 1'b0, 1'b1, 4'd2);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      rop   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(4, 7));
      rdata = {rop, 28'($urandom)};
      do_fetch(int'($urandom_range(0, 3)), rdata, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom));
      if ($urandom_range(0, 1) == 1) do_branch(4'($urandom));
    end

    // Reset in the middle of a fetch.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("mid_req_pre", bus.im_req, 1);
    #2;
    rst = 1'b1;
    #1;
    m_pc = 0;
    m_ir = 32'd0;
    m_err = 1'b0;
    chk("mid_req", bus.im_req, 0);
    chk("mid_pc", pc, 0);
    chk("mid_ir", ir, 0);
    chk("mid_busy", busy, 0);
    step();
    rst = 1'b0;
    bus.im_ack  = 1'b1;
    bus.im_data = 32'hDEAD_BEEF;
    step();
    step();
    bus.im_ack = 1'b0;
    chk("post_rst_ir", ir, 0);
    chk("post_rst_pc", pc, 0);
    chk("post_rst_busy", busy, 0);

`ifdef FETCH_TIMEOUT_EN
    // No ack: abort after 16 waiting cycles.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_busy", busy, 1);
      step();
    end
    chk("to_done", fetch_done, 1);
    chk("to_ir", ir, 32'hF000_0000);
    chk("to_opcode", opcode, 4'd15);
    chk("to_err", fetch_err, 1);
    chk("to_pc", pc, m_pc);
    bus.im_ack  = 1'b1;
    bus.im_data = 32'h1111_1111;
    step();
    step();
    bus.im_ack = 1'b0;
    chk("to_late_ir", ir, 32'hF000_0000);
    chk("to_sticky", fetch_err, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
